// File: rtl/led_arbiter.sv
// led_arbiter: round-robin sharing of the 3 board LEDs between NREQ status
// requesters. A grant lasts at most HOLD prescaler ticks or until the grantee
// drops its request. Every grant end is followed by one dark cycle.
// The grantee's pattern drives the active-low LED pins.
//
// Ports:
//   clk    in   1       system clock
//   n_rst  in   1       asynchronous active-low reset
//   req    in   NREQ    request vector, bit i = requester i wants the LEDs
//   pat    in   3*NREQ  pattern of requester i at pat[3*i+:3], 1 = LED lit
//   gnt    out  NREQ    one-hot grant (registered), zero when idle
//   led    out  3       LED pins, active-low (registered)
//
// Optional feature: define LED_ARB_PRIO_EN to give requester 0 preemptive
// priority. Without it, arbitration is pure round-robin.

module led_arbiter #(
   parameter int unsigned CDIV = 3,
   parameter int unsigned NREQ = 3,
   parameter int unsigned HOLD = 2
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [NREQ-1:0]       req,
   input  logic [3*NREQ-1:0]     pat,
   output logic [NREQ-1:0]       gnt,
   output logic [2:0]            led
);

   localparam int unsigned CW = $clog2(CDIV + 1);
   localparam int unsigned HW = $clog2(HOLD + 1);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state, state_d;
   logic [CW-1:0]   counter, counter_d;
   logic [HW-1:0]   hold_cnt, hold_d;
   logic [IW-1:0]   last, last_d;
   logic [NREQ-1:0] gnt_d;
   logic [2:0]      led_d;

   logic            tick_c;
   logic            pick_valid_c;
   logic [IW-1:0]   pick_c;
   logic [2:0]      pick_pat_c;
   logic [2:0]      cur_pat_c;
   logic            cur_req_c;
   logic            prio_hit_c;
   logic            exit_c;

   // Prescaler tick: counter sits at 0 only out of reset, then cycles 1..CDIV.
   assign tick_c = (counter == CW'(CDIV));

   // Round-robin search starting just after the last grantee; the descending
   // loop leaves the nearest requester in pick_c.
   always_comb begin
      logic [IW-1:0] idx;
      pick_valid_c = 1'b0;
      pick_c       = last;
      idx          = '0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         idx = IW'((32'(last) + k) % NREQ);
         if (req[idx]) begin
            pick_c       = idx;
            pick_valid_c = 1'b1;
         end
      end
`ifdef LED_ARB_PRIO_EN
      // Requester 0 wins an idle arbitration outright.
      if (req[0]) begin
         pick_c       = '0;
         pick_valid_c = 1'b1;
      end
`endif
   end

   // Pattern and request of the candidate and of the current grantee.
   // The current grantee index is always held in last while granting.
   always_comb begin
      pick_pat_c = 3'b000;
      cur_pat_c  = 3'b000;
      cur_req_c  = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (IW'(i) == pick_c) pick_pat_c = pat[3*i +: 3];
         if (IW'(i) == last) begin
            cur_pat_c = pat[3*i +: 3];
            cur_req_c = req[i];
         end
      end
   end

   // Preemption request from requester 0 while someone else holds the LEDs.
`ifdef LED_ARB_PRIO_EN
   assign prio_hit_c = req[0] && (last != '0);
`else
   assign prio_hit_c = 1'b0;
`endif

   // Grant ends on release, on the HOLD-th tick, or on preemption; any
   // combination of these is a single exit.
   assign exit_c = !cur_req_c
                || (tick_c && (hold_cnt == HW'(HOLD - 1)))
                || prio_hit_c;

   // Next-state and output logic.
   always_comb begin
      state_d   = state;
      counter_d = tick_c ? CW'(1) : counter + CW'(1);
      hold_d    = hold_cnt;
      last_d    = last;
      gnt_d     = gnt;
      led_d     = led;
      case (state)
         IDLE: begin
            gnt_d = '0;
            led_d = 3'b111;
            if (pick_valid_c) begin
               gnt_d   = NREQ'(1) << pick_c;
               led_d   = ~pick_pat_c;
               last_d  = pick_c;
               hold_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            led_d = ~cur_pat_c;
            if (tick_c) hold_d = hold_cnt + HW'(1);
            if (exit_c) begin
               state_d = IDLE;
               gnt_d   = '0;
               led_d   = 3'b111;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            led_d   = 3'b111;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         counter  <= '0;
         hold_cnt <= '0;
         last     <= IW'(NREQ - 1);
         gnt      <= '0;
         led      <= 3'b111;
      end else begin
         state    <= state_d;
         counter  <= counter_d;
         hold_cnt <= hold_d;
         last     <= last_d;
         gnt      <= gnt_d;
         led      <= led_d;
      end
   end

`ifndef SYNTHESIS
   // Structural invariants of the arbiter outputs.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         assert ($onehot0(gnt)) else $error("gnt multi-hot: %b", gnt);
         assert ((gnt != '0) || (led == 3'b111)) else $error("led lit without grant");
      end
   end
`endif

endmodule
